// File: rtl/cpu_ctl_pkg.sv
// Shared definitions for the single-bus CPU control sequencers:
// opcodes, ALU operation codes, step states and IR field positions.
package cpu_ctl_pkg;

    // Instruction opcodes (ir[31:27])
    localparam logic [4:0] OP_ADD = 5'b00011;
    localparam logic [4:0] OP_SUB = 5'b00100;
    localparam logic [4:0] OP_SHR = 5'b00101;
    localparam logic [4:0] OP_SHL = 5'b00110;
    localparam logic [4:0] OP_ROR = 5'b00111;
    localparam logic [4:0] OP_ROL = 5'b01000;
    localparam logic [4:0] OP_AND = 5'b01001;
    localparam logic [4:0] OP_OR  = 5'b01010;
    localparam logic [4:0] OP_MUL = 5'b01110;
    localparam logic [4:0] OP_DIV = 5'b01111;
    localparam logic [4:0] OP_NEG = 5'b10000;
    localparam logic [4:0] OP_NOT = 5'b10001;

    // ALU operation codes; 0 leaves the ALU idle
    localparam logic [3:0] ALU_IDLE = 4'd0;
    localparam logic [3:0] ALU_ADD  = 4'd1;
    localparam logic [3:0] ALU_SUB  = 4'd2;
    localparam logic [3:0] ALU_MUL  = 4'd3;
    localparam logic [3:0] ALU_DIV  = 4'd4;
    localparam logic [3:0] ALU_SHR  = 4'd5;
    localparam logic [3:0] ALU_SHL  = 4'd6;
    localparam logic [3:0] ALU_ROR  = 4'd7;
    localparam logic [3:0] ALU_ROL  = 4'd8;
    localparam logic [3:0] ALU_AND  = 4'd9;
    localparam logic [3:0] ALU_OR   = 4'd10;
    localparam logic [3:0] ALU_NOT  = 4'd11;
    localparam logic [3:0] ALU_NEG  = 4'd12;

    // Control steps of one fetch+execute
    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_T4   = 3'd5,
        S_T5   = 3'd6,
        S_T6   = 3'd7
    } step_t;

    // IR field bit positions
    localparam int OP_HI = 31;
    localparam int OP_LO = 27;
    localparam int RA_HI = 26;
    localparam int RA_LO = 23;
    localparam int RB_HI = 22;
    localparam int RB_LO = 19;
    localparam int RC_HI = 18;
    localparam int RC_LO = 15;

endpackage

// File: rtl/op_decode.sv
// Combinational opcode classifier shared by the control sequencers.
module op_decode
    import cpu_ctl_pkg::*;
(
    input  logic [4:0] op,
    output logic       legal,
    output logic       is_muldiv,
    output logic       is_unary,
    output logic [3:0] alu_ctl
);

    // Map opcode to legality, instruction class and ALU operation
    always_comb begin
        legal     = 1'b1;
        is_muldiv = 1'b0;
        is_unary  = 1'b0;
        alu_ctl   = ALU_IDLE;
        case (op)
            OP_ADD: alu_ctl = ALU_ADD;
            OP_SUB: alu_ctl = ALU_SUB;
            OP_SHR: alu_ctl = ALU_SHR;
            OP_SHL: alu_ctl = ALU_SHL;
            OP_ROR: alu_ctl = ALU_ROR;
            OP_ROL: alu_ctl = ALU_ROL;
            OP_AND: alu_ctl = ALU_AND;
            OP_OR:  alu_ctl = ALU_OR;
            OP_MUL: begin alu_ctl = ALU_MUL; is_muldiv = 1'b1; end
            OP_DIV: begin alu_ctl = ALU_DIV; is_muldiv = 1'b1; end
            OP_NEG: begin alu_ctl = ALU_NEG; is_unary  = 1'b1; end
            OP_NOT: begin alu_ctl = ALU_NOT; is_unary  = 1'b1; end
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_step_sequencer.sv
// Moore control-step sequencer: fetches one instruction and runs a
// register-to-register ALU instruction through steps T0..T6.
// Handshake: start is a level sampled only in IDLE; mem_ready qualifies
// the memory read in T1 (T1 holds with mem_read high until mem_ready=1).
module alu_step_sequencer
    import cpu_ctl_pkg::*;
#(
    parameter int unsigned MULDIV_WAIT = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] ir,
    input  logic        mem_ready,
    output logic        pc_out,
    output logic        mar_in,
    output logic        inc_pc,
    output logic        mem_read,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlo_out,
    output logic        zhi_out,
    output logic        lo_in,
    output logic        hi_in,
    output logic        pc_in,
    output logic        reg_out,
    output logic        reg_in,
    output logic [3:0]  reg_sel,
    output logic [3:0]  alu_ctl,
    output logic        busy,
    output logic        done,
    output logic        illegal,
    output step_t       step
);

    step_t      state;
    step_t      state_next;
    logic [3:0] wait_cnt;
    logic       last_wait;
    logic       legal;
    logic       is_muldiv;
    logic       is_unary;
    logic [3:0] dec_alu;
    logic [3:0] ra;
    logic [3:0] rb;
    logic [3:0] rc;
    logic       unused_ir;

    assign ra        = ir[RA_HI:RA_LO];
    assign rb        = ir[RB_HI:RB_LO];
    assign rc        = ir[RC_HI:RC_LO];
    assign unused_ir = ^ir[RC_LO-1:0];
    assign last_wait = (wait_cnt == 4'(MULDIV_WAIT - 1));
    assign step      = state;

    op_decode u_op_decode (
        .op        (ir[OP_HI:OP_LO]),
        .legal     (legal),
        .is_muldiv (is_muldiv),
        .is_unary  (is_unary),
        .alu_ctl   (dec_alu)
    );

    // State register and mul/div settle counter (counts only inside T4)
    always_ff @(posedge clock) begin
        if (reset) begin
            state    <= S_IDLE;
            wait_cnt <= 4'd0;
        end else begin
            state <= state_next;
            if (state == S_T4 && is_muldiv && !last_wait)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
        end
    end

    // Next-step selection
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: if (start) state_next = S_T0;
            S_T0:   state_next = S_T1;
            S_T1:   if (mem_ready) state_next = S_T2;
            S_T2:   state_next = S_T3;
            S_T3:   state_next = legal ? S_T4 : S_IDLE;
            S_T4:   if (!is_muldiv || last_wait) state_next = S_T5;
            S_T5:   state_next = is_muldiv ? S_T6 : S_IDLE;
            S_T6:   state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Strobe decode from the current step (and IR class / mem_ready)
    always_comb begin
        pc_out   = 1'b0;
        mar_in   = 1'b0;
        inc_pc   = 1'b0;
        mem_read = 1'b0;
        mdr_in   = 1'b0;
        mdr_out  = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        z_in     = 1'b0;
        zlo_out  = 1'b0;
        zhi_out  = 1'b0;
        lo_in    = 1'b0;
        hi_in    = 1'b0;
        pc_in    = 1'b0;
        reg_out  = 1'b0;
        reg_in   = 1'b0;
        reg_sel  = 4'd0;
        alu_ctl  = ALU_IDLE;
        busy     = (state != S_IDLE);
        done     = 1'b0;
        illegal  = 1'b0;
        case (state)
            S_T0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            S_T1: begin
                mem_read = 1'b1;
                if (mem_ready) begin
                    mdr_in  = 1'b1;
                    zlo_out = 1'b1;
                    pc_in   = 1'b1;
                end
            end
            S_T2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            S_T3: begin
                if (!legal) begin
                    illegal = 1'b1;
                end else begin
                    reg_out = 1'b1;
                    y_in    = 1'b1;
                    reg_sel = is_muldiv ? ra : rb;
                end
            end
            S_T4: begin
                reg_out = 1'b1;
                alu_ctl = dec_alu;
                reg_sel = (is_muldiv || is_unary) ? rb : rc;
                z_in    = !is_muldiv || last_wait;
            end
            S_T5: begin
                zlo_out = 1'b1;
                if (is_muldiv) begin
                    lo_in = 1'b1;
                end else begin
                    reg_in  = 1'b1;
                    reg_sel = ra;
                    done    = 1'b1;
                end
            end
            S_T6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_step_sequencer.sv
// Self-checking bench for alu_step_sequencer: every scenario builds the
// expected per-cycle strobe trace of whole instructions from the
// instruction-level rules, then drives and compares cycle by cycle.
module tb_alu_step_sequencer;

    localparam int MW = 4;

    typedef struct packed {
        logic       pc_out;
        logic       mar_in;
        logic       inc_pc;
        logic       mem_read;
        logic       mdr_in;
        logic       mdr_out;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       zlo_out;
        logic       zhi_out;
        logic       lo_in;
        logic       hi_in;
        logic       pc_in;
        logic       reg_out;
        logic       reg_in;
        logic [3:0] reg_sel;
        logic [3:0] alu_ctl;
        logic       busy;
        logic       done;
        logic       illegal;
    } sig_t;

    typedef struct {
        logic        start;
        logic        mem_ready;
        logic        rst;
        logic [31:0] ir;
        sig_t        exp;
    } cyc_t;

    // ---------------- clock / reset ----------------
    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        mem_ready = 1'b0;
    logic [31:0] ir = 32'd0;

    logic pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in, y_in, z_in;
    logic zlo_out, zhi_out, lo_in, hi_in, pc_in, reg_out, reg_in;
    logic [3:0] reg_sel, alu_ctl;
    logic busy, done, illegal;
    logic [2:0] step;
    sig_t obs;

    int errors = 0;
    int checks = 0;
    cyc_t exp_q[$];

    always #5 clock = ~clock;

    assign obs = {pc_out, mar_in, inc_pc, mem_read, mdr_in, mdr_out, ir_in, y_in,
                  z_in, zlo_out, zhi_out, lo_in, hi_in, pc_in, reg_out, reg_in,
                  reg_sel, alu_ctl, busy, done, illegal};

    alu_step_sequencer #(.MULDIV_WAIT(MW)) dut (
        .clock(clock), .reset(reset), .start(start), .ir(ir), .mem_ready(mem_ready),
        .pc_out(pc_out), .mar_in(mar_in), .inc_pc(inc_pc), .mem_read(mem_read),
        .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in), .y_in(y_in), .z_in(z_in),
        .zlo_out(zlo_out), .zhi_out(zhi_out), .lo_in(lo_in), .hi_in(hi_in),
        .pc_in(pc_in), .reg_out(reg_out), .reg_in(reg_in), .reg_sel(reg_sel),
        .alu_ctl(alu_ctl), .busy(busy), .done(done), .illegal(illegal), .step(step)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    // Instruction class: -1 illegal, 0 binary, 1 unary (neg/not), 2 mul/div
    function automatic int ref_op(input logic [4:0] op, output logic [3:0] code);
        code = 4'd0;
        case (op)
            5'b00011: begin code = 4'd1;  return 0; end
            5'b00100: begin code = 4'd2;  return 0; end
            5'b00101: begin code = 4'd5;  return 0; end
            5'b00110: begin code = 4'd6;  return 0; end
            5'b00111: begin code = 4'd7;  return 0; end
            5'b01000: begin code = 4'd8;  return 0; end
            5'b01001: begin code = 4'd9;  return 0; end
            5'b01010: begin code = 4'd10; return 0; end
            5'b01110: begin code = 4'd3;  return 2; end
            5'b01111: begin code = 4'd4;  return 2; end
            5'b10000: begin code = 4'd12; return 1; end
            5'b10001: begin code = 4'd11; return 1; end
            default:  return -1;
        endcase
    endfunction

    function automatic logic pick_start(input int smode);
        if (smode == 0) return 1'b0;
        if (smode == 2) return 1'b1;
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic s, input logic mr, input logic [31:0] instr,
                                 input sig_t e);
        cyc_t c;
        c.start     = s;
        c.mem_ready = mr;
        c.rst       = 1'b0;
        c.ir        = instr;
        c.exp       = e;
        exp_q.push_back(c);
    endfunction

    function automatic logic rnd_bit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expected trace of one instruction, starting with the IDLE cycle where start=1.
    // smode selects start during busy cycles: 0 low, 1 random, 2 held high.
    function automatic void build_instr(input logic [31:0] instr, input int stalls,
                                        input int smode);
        sig_t s;
        logic [3:0] code;
        logic [3:0] ra, rb, rc;
        int kind;
        int n;
        ra = instr[26:23];
        rb = instr[22:19];
        rc = instr[18:15];
        kind = ref_op(instr[31:27], code);
        s = '0;
        push(1'b1, rnd_bit(), instr, s);
        s = '0; s.busy = 1; s.pc_out = 1; s.mar_in = 1; s.inc_pc = 1; s.z_in = 1;
        push(pick_start(smode), rnd_bit(), instr, s);
        for (int k = 0; k < stalls; k++) begin
            s = '0; s.busy = 1; s.mem_read = 1;
            push(pick_start(smode), 1'b0, instr, s);
        end
        s = '0; s.busy = 1; s.mem_read = 1; s.mdr_in = 1; s.zlo_out = 1; s.pc_in = 1;
        push(pick_start(smode), 1'b1, instr, s);
        s = '0; s.busy = 1; s.mdr_out = 1; s.ir_in = 1;
        push(pick_start(smode), rnd_bit(), instr, s);
        if (kind < 0) begin
            s = '0; s.busy = 1; s.illegal = 1;
            push(pick_start(smode), rnd_bit(), instr, s);
            return;
        end
        s = '0; s.busy = 1; s.reg_out = 1; s.y_in = 1;
        s.reg_sel = (kind == 2) ? ra : rb;
        push(pick_start(smode), rnd_bit(), instr, s);
        n = (kind == 2) ? MW : 1;
        for (int k = 0; k < n; k++) begin
            s = '0; s.busy = 1; s.reg_out = 1; s.alu_ctl = code;
            s.reg_sel = (kind == 0) ? rc : rb;
            s.z_in = (k == n - 1);
            push(pick_start(smode), rnd_bit(), instr, s);
        end
        if (kind != 2) begin
            s = '0; s.busy = 1; s.zlo_out = 1; s.reg_in = 1; s.reg_sel = ra; s.done = 1;
            push(pick_start(smode), rnd_bit(), instr, s);
        end else begin
            s = '0; s.busy = 1; s.zlo_out = 1; s.lo_in = 1;
            push(pick_start(smode), rnd_bit(), instr, s);
            s = '0; s.busy = 1; s.zhi_out = 1; s.hi_in = 1; s.done = 1;
            push(pick_start(smode), rnd_bit(), instr, s);
        end
    endfunction

    function automatic void push_idle(input int count);
        for (int k = 0; k < count; k++) push(1'b0, rnd_bit(), 32'd0, sig_t'('0));
    endfunction

    // ---------------- driver tasks ----------------
    // Apply one cycle of inputs just after the rising edge, then move to the
    // falling edge where outputs are sampled.
    task automatic apply_cycle(input cyc_t c);
        ir        = c.ir;
        start     = c.start;
        mem_ready = c.mem_ready;
        reset     = c.rst;
        @(negedge clock);
    endtask

    task automatic next_edge();
        @(posedge clock);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1; start = 1'b1; mem_ready = 1'b1; ir = 32'h1891_8000;
        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        checks++;
        if (obs !== sig_t'('0)) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected %h", obs, sig_t'('0));
        end
        next_edge();
        reset = 1'b0; start = 1'b0;
        @(negedge clock);
        checks++;
        if (obs !== sig_t'('0)) begin
            errors++;
            $display("FAIL reset_idle: got %h expected %h", obs, sig_t'('0));
        end
        next_edge();
    endtask

    task automatic run_latency(input string name, input logic [31:0] instr,
                               input int stalls, input int exp_done);
        cyc_t c;
        int idx;
        int done_at;
        idx = 0;
        done_at = -1;
        build_instr(instr, stalls, 0);
        push_idle(1);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            apply_cycle(c);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, idx, obs, c.exp);
            end
            if (obs.done && done_at < 0) done_at = idx;
            idx++;
            next_edge();
        end
        checks++;
        if (done_at !== exp_done) begin
            errors++;
            $display("FAIL %s latency: done at cycle %0d expected %0d", name, done_at, exp_done);
        end
    endtask

    task automatic test_add();
        run_latency("add", 32'h1891_8000, 0, 6);
    endtask

    task automatic test_mem_stall();
        run_latency("mem_stall", 32'h1891_8000, 3, 9);
    endtask

    task automatic test_mul();
        run_latency("mul", 32'h7228_0000, 0, 6 + MW);
        run_latency("div", {5'b01111, 4'd7, 4'd9, 4'd2, 15'd0}, 1, 7 + MW);
    endtask

    task automatic test_illegal();
        cyc_t c;
        int idx;
        logic [31:0] instr;
        idx = 0;
        instr = {5'b00000, 27'($urandom())};
        build_instr(instr, 0, 0);
        push_idle(2);
        instr = {5'b11111, 27'($urandom())};
        build_instr(instr, 2, 1);
        push_idle(2);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            apply_cycle(c);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL illegal cycle %0d: got %h expected %h", idx, obs, c.exp);
            end
            idx++;
            next_edge();
        end
    endtask

    task automatic test_reset_mid();
        cyc_t c;
        int idx;
        idx = 0;
        build_instr(32'h7228_0000, 0, 0);
        // keep idle, T0, T1, T2, T3 and two T4 cycles; reset during the second T4
        while (exp_q.size() > 7) void'(exp_q.pop_back());
        exp_q[6].rst = 1'b1;
        push_idle(2);
        build_instr(32'h2092_0000, 0, 0);
        push_idle(1);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            apply_cycle(c);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", idx, obs, c.exp);
            end
            idx++;
            next_edge();
        end
        reset = 1'b0;
    endtask

    task automatic test_back_to_back();
        cyc_t c;
        int idx;
        int dones;
        idx = 0;
        dones = 0;
        // start pulsed only in T2: must be ignored, exactly one done
        build_instr(32'h1891_8000, 0, 0);
        exp_q[3].start = 1'b1;
        push_idle(3);
        // start held high through three chained instructions
        build_instr(32'h2092_0000, 1, 2);
        build_instr(32'h7228_0000, 0, 2);
        build_instr(32'h8010_0000, 2, 2);
        push_idle(2);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            apply_cycle(c);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: got %h expected %h", idx, obs, c.exp);
            end
            if (obs.done) dones++;
            idx++;
            next_edge();
        end
        checks++;
        if (dones !== 4) begin
            errors++;
            $display("FAIL back_to_back done_count: got %0d expected %0d", dones, 4);
        end
    endtask

    task automatic test_random();
        cyc_t c;
        int idx;
        logic [4:0] op;
        logic [4:0] legal_ops[12];
        legal_ops = '{5'b00011, 5'b00100, 5'b00101, 5'b00110, 5'b00111, 5'b01000,
                      5'b01001, 5'b01010, 5'b01110, 5'b01111, 5'b10000, 5'b10001};
        idx = 0;
        for (int n = 0; n < 40; n++) begin
            if ($urandom_range(0, 3) != 0) op = legal_ops[$urandom_range(0, 11)];
            else op = 5'($urandom_range(0, 31));
            build_instr({op, 27'($urandom())}, $urandom_range(0, 3), $urandom_range(0, 2));
            if ($urandom_range(0, 1) == 1) push_idle($urandom_range(1, 2));
        end
        push_idle(1);
        while (exp_q.size() > 0) begin
            c = exp_q.pop_front();
            apply_cycle(c);
            checks++;
            if (obs !== c.exp) begin
                errors++;
                $display("FAIL random cycle %0d: got %h expected %h", idx, obs, c.exp);
            end
            idx++;
            next_edge();
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_add();
        test_mem_stall();
        test_mul();
        test_illegal();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/alu_step_sequencer.md
Name: alu_step_sequencer

Overview:
Moore control-step sequencer for the single-bus CPU datapath.
- Fetches one instruction, then runs a register-to-register ALU instruction through steps T0..T6.
- Drives the bus gating and register-enable strobes, the memory read handshake, and the 4-bit ALU operation code.
- Sits between the top-level run control and the datapath. Each `start` produces exactly one instruction.

Parameters:
- MULDIV_WAIT, default 4: cycles T4 is held for mul/div so the combinational result settles; legal range 1..15.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- start  in  1  begin one fetch+execute; sampled only in IDLE
- ir  in  32  IR contents; decoded from T3 on
- mem_ready  in  1  memory read data valid
- pc_out, mar_in, inc_pc  out  1 each  T0 strobes
- mem_read, mdr_in  out  1 each  memory read and MDR load
- mdr_out, ir_in  out  1 each  T2 strobes
- y_in, z_in, zlo_out, zhi_out, lo_in, hi_in, pc_in  out  1 each  datapath enables
- reg_out, reg_in  out  1 each  general-register bus drive / load
- reg_sel  out  4  register selected for reg_out/reg_in
- alu_ctl  out  4  ALU op: 1 add, 2 sub, 3 mul, 4 div, 5 shr, 6 shl, 7 ror, 8 rol, 9 and, 10 or, 11 not, 12 neg; 0 = idle
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse in the final step
- illegal  out  1  one-cycle pulse on an unsupported opcode

Behaviour:
- **Reset.** Synchronous reset has priority, including mid-instruction. Next state is IDLE, the wait counter clears, and every output is 0 (all outputs decode from state).
- **IR fields.** op = ir[31:27], ra = ir[26:23], rb = ir[22:19], rc = ir[18:15].
- **Supported opcodes.**
  - add 00011, sub 00100, shr 00101, shl 00110, ror 00111, rol 01000, and 01001, or 01010.
  - mul 01110, div 01111, neg 10000, not 10001.
  - All other opcodes are illegal.
- **States.** IDLE, T0, T1, T2, T3, T4, T5, T6.
- **IDLE.** All outputs 0. If start=1, go to T0; otherwise stay.
- **T0.** pc_out, mar_in, inc_pc, z_in. Go to T1.
- **T1.** mem_read=1 every cycle. Stay while mem_ready=0. In the cycle mem_ready=1, also assert mdr_in, zlo_out and pc_in, then go to T2.
- **T2.** mdr_out, ir_in. Go to T3.
- **T3.**
  - If op is illegal: illegal=1, no other strobe except busy; go to IDLE.
  - Binary ops: reg_out, y_in, reg_sel=rb.
  - neg/not: reg_out, y_in, reg_sel=rb.
  - mul/div: reg_out, y_in, reg_sel=ra.
  - Then go to T4.
- **T4.** reg_out=1 and alu_ctl = decoded op for every T4 cycle.
  - reg_sel: rc for binary ops, rb for neg/not, rb for mul/div.
  - Non-mul/div ops: z_in=1, one cycle, go to T5.
  - mul/div: T4 lasts exactly MULDIV_WAIT cycles, counted by the wait counter; z_in=1 only in the last of them; then go to T5.
- **T5.**
  - Non-mul/div ops: zlo_out, reg_in, reg_sel=ra, done=1; go to IDLE.
  - mul/div: zlo_out, lo_in; go to T6.
- **T6.** zhi_out, hi_in, done=1. Go to IDLE.
- **Latency.** With mem_ready=1 in the first T1 cycle, start sampled at cycle 0 gives done at cycle 6 for ALU ops. For mul/div, done comes at cycle 6+MULDIV_WAIT.
- **start while busy.** Ignored, not queued. start held high in the IDLE cycle after done launches the next fetch.
- **No overlap.** done and illegal never assert in the same cycle. reg_out and reg_in are never both high.
- **Other outputs.** alu_ctl=0 outside T4; reg_sel=0 whenever reg_out and reg_in are both 0.

Decomposition:
- Shared package `cpu_ctl_pkg`:
  - opcode localparams (OP_ADD = 5'b00011 ... OP_NOT = 5'b10001);
  - ALU code localparams (ALU_ADD = 4'd1 ... ALU_NEG = 4'd12);
  - step-state enum;
  - IR field slice constants.
- One sub-module, `op_decode`: combinational op → {legal, is_muldiv, is_unary, alu_ctl}. It is reused later by immediate and branch sequencers.

Test Plan:
1. **add.** reset 2 cycles, start=1 one cycle, ir=0x18918000 (add r1,r2,r3), mem_ready=1 → steps T0..T5 in 6 consecutive cycles. T3 reg_sel=2, y_in. T4 reg_sel=3, alu_ctl=1, z_in. T5 reg_sel=1, reg_in, done.
2. **mem stall.** Same add with mem_ready low for 3 cycles in T1 → mem_read high 4 cycles; mdr_in/pc_in only in the 4th; done 3 cycles later than scenario 1.
3. **mul.** ir=0x72280000 (mul r4,r5), MULDIV_WAIT=4 → T3 reg_sel=4. T4 alu_ctl=3 for 4 cycles, reg_sel=5, z_in only in the 4th. T5 lo_in. T6 hi_in, done. reg_in never asserted.
4. **illegal opcode.** ir opcode 00000 → illegal pulse in T3, back to IDLE next cycle, no y_in/z_in/reg_in/done.
5. **reset mid-instruction.** Assert reset during T4 of the mul → next cycle all outputs 0, busy=0. A later start runs a full clean instruction.
6. **start while busy / back-to-back.** start pulsed during T2 → ignored, exactly one done. start held high continuously → T0 in the cycle after IDLE following each done.
